// File: rtl/aes_wb_regfile_if.sv
// rtl/aes_wb_regfile_if.sv - Wishbone slave bus bundle for the AES register bank
interface aes_wb_regfile_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    output wbs_we_i,
    output wbs_sel_i,
    output wbs_adr_i,
    output wbs_dat_i,
    input  wbs_ack_o,
    input  wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    input  wbs_we_i,
    input  wbs_sel_i,
    input  wbs_adr_i,
    input  wbs_dat_i,
    output wbs_ack_o,
    output wbs_dat_o
  );
endinterface

// File: rtl/aes_wb_regfile.sv
// rtl/aes_wb_regfile.sv - Wishbone register bank feeding key/block/mode/start to the AES core
module aes_wb_regfile #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic        IRQ_DEFAULT_EN = 1'b0
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  aes_wb_regfile_if.slave wb,
  output logic [127:0]   aes_key_o,
  output logic [127:0]   aes_din_o,
  output logic           aes_mode_o,
  output logic           aes_start_o,
  input  logic           aes_done_i,
  input  logic [127:0]   aes_dout_i,
  output logic           irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] key_q  [4];
  logic [31:0] din_q  [4];
  logic [31:0] dout_q [4];
  logic        mode_q;
  logic        irq_en_q;
  logic        done_q;
  logic        err_q;
  logic        irq_q;
  logic        ack_q;
  logic [31:0] dat_q;

  logic        sel_hit;
  logic        access;
  logic        wr;
  logic        busy;
  logic [5:0]  word;
  logic [1:0]  idx;
  logic        aligned;
  logic        is_ctrl;
  logic        is_status;
  logic        is_key;
  logic        is_din;
  logic        is_dout;
  logic        reg_wr;
  logic        start_req;
  logic        err_set;
  logic        done_set;
  logic        w1c;
  logic [31:0] rdata;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? data[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  // An access is taken only while ack is low, so a held strobe yields ack every other cycle.
  assign sel_hit = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access  = sel_hit & ~ack_q;
  assign wr      = access & wb.wbs_we_i;
  assign busy    = (state != ST_IDLE);

  assign word      = wb.wbs_adr_i[7:2];
  assign idx       = word[1:0];
  assign aligned   = (wb.wbs_adr_i[1:0] == 2'b00);
  assign is_ctrl   = aligned & (word == 6'd0);
  assign is_status = aligned & (word == 6'd1);
  assign is_key    = aligned & (word[5:2] == 4'd1);
  assign is_din    = aligned & (word[5:2] == 4'd2);
  assign is_dout   = aligned & (word[5:2] == 4'd3);

  assign reg_wr    = wr & ~busy;
  assign start_req = reg_wr & is_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
  assign err_set   = wr & busy & (is_ctrl | is_key | is_din);
  assign done_set  = (state == ST_BUSY) & aes_done_i;
  assign w1c       = wr & is_status & wb.wbs_sel_i[0];

  always_comb begin
    rdata = 32'h0;
    if (is_ctrl) begin
      rdata = {29'h0, irq_en_q, mode_q, 1'b0};
    end else if (is_status) begin
      rdata = {29'h0, err_q, done_q, busy};
    end else if (is_din) begin
      rdata = din_q[idx];
    end else if (is_dout) begin
      rdata = dout_q[idx];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    aes_start_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        aes_start_o = 1'b1;
        state_nxt   = ST_BUSY;
      end
      ST_BUSY: begin
        if (aes_done_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= 32'h0;
        din_q[i]  <= 32'h0;
        dout_q[i] <= 32'h0;
      end
      mode_q   <= 1'b0;
      irq_en_q <= IRQ_DEFAULT_EN;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
    end else begin
      ack_q <= access;
      dat_q <= (access && !wb.wbs_we_i) ? rdata : 32'h0;
      irq_q <= done_q & irq_en_q;

      if (reg_wr && is_key) begin
        key_q[idx] <= byte_merge(key_q[idx], wb.wbs_dat_i, wb.wbs_sel_i);
      end
      if (reg_wr && is_din) begin
        din_q[idx] <= byte_merge(din_q[idx], wb.wbs_dat_i, wb.wbs_sel_i);
      end
      // Mode lands on the same edge as the start request, so the new operation uses it.
      if (reg_wr && is_ctrl && wb.wbs_sel_i[0]) begin
        mode_q   <= wb.wbs_dat_i[1];
        irq_en_q <= wb.wbs_dat_i[2];
      end

      if (done_set) begin
        dout_q[0] <= aes_dout_i[127:96];
        dout_q[1] <= aes_dout_i[95:64];
        dout_q[2] <= aes_dout_i[63:32];
        dout_q[3] <= aes_dout_i[31:0];
      end

      if (done_set) begin
        done_q <= 1'b1;
      end else if (start_req || (w1c && wb.wbs_dat_i[1])) begin
        done_q <= 1'b0;
      end

      if (err_set) begin
        err_q <= 1'b1;
      end else if (w1c && wb.wbs_dat_i[2]) begin
        err_q <= 1'b0;
      end
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign aes_key_o    = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_din_o    = {din_q[0], din_q[1], din_q[2], din_q[3]};
  assign aes_mode_o   = mode_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_aes_wb_regfile.sv
// tb/tb_aes_wb_regfile.sv - Randomized self-checking bench for aes_wb_regfile against a register-map model
module tb_aes_wb_regfile;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key;
  logic [127:0] din;
  logic         mode;
  logic         start;
  logic         done_in = 1'b0;
  logic [127:0] dout_core = '0;
  logic         irq;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  logic [31:0]  m_key [4];
  logic [31:0]  m_din [4];
  logic [127:0] m_dout;
  logic         m_mode, m_irq_en, m_done, m_err, m_busy;
  int           m_starts;

  logic [7:0] offs [19] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                            8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C,
                            8'h40, 8'hFC, 8'h21};

  always #5 clk = ~clk;

  aes_wb_regfile_if bus();

  aes_wb_regfile #(.BASE_ADDR(BASE), .IRQ_DEFAULT_EN(1'b0)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus),
    .aes_key_o  (key),
    .aes_din_o  (din),
    .aes_mode_o (mode),
    .aes_start_o(start),
    .aes_done_i (done_in),
    .aes_dout_i (dout_core),
    .irq_o      (irq)
  );

  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_key[i] = '0; m_din[i] = '0; end
    m_dout = '0; m_mode = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0; m_starts = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [127:0] d;
    d = m_dout;
    case (off)
      8'h00: return {29'h0, m_irq_en, m_mode, 1'b0};
      8'h04: return {29'h0, m_err, m_done, m_busy};
      8'h20, 8'h24, 8'h28, 8'h2C: return m_din[(off - 8'h20) / 4];
      8'h30: return d[127:96];
      8'h34: return d[95:64];
      8'h38: return d[63:32];
      8'h3C: return d[31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be,
                             input logic done_now, input logic [127:0] dres);
    logic was_busy;
    logic is_key, is_din;
    was_busy = m_busy;
    is_key = (off >= 8'h10) && (off <= 8'h1C) && (off[1:0] == 2'b00);
    is_din = (off >= 8'h20) && (off <= 8'h2C) && (off[1:0] == 2'b00);
    if (was_busy) begin
      if (off == 8'h00 || is_key || is_din) m_err = 1;
    end else begin
      if (is_key) m_key[(off - 8'h10) / 4] = merge_bytes(m_key[(off - 8'h10) / 4], d, be);
      if (is_din) m_din[(off - 8'h20) / 4] = merge_bytes(m_din[(off - 8'h20) / 4], d, be);
      if (off == 8'h00 && be[0]) begin
        m_mode = d[1];
        m_irq_en = d[2];
        if (d[0]) begin m_busy = 1; m_done = 0; m_starts++; end
      end
    end
    if (off == 8'h04 && be[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end
    if (done_now && was_busy) begin m_busy = 0; m_done = 1; m_dout = dres; end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
  endtask

  task automatic wb_access(input logic we, input logic [7:0] off, input logic [31:0] data,
                           input logic [3:0] be, input logic pulse_done, input logic [127:0] dres,
                           output logic [31:0] rd);
    int n;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_sel_i = be; bus.wbs_adr_i = BASE | {24'h0, off}; bus.wbs_dat_i = data;
    if (pulse_done) begin done_in = 1; dout_core = dres; end
    n = 0;
    rd = '0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      done_in = 0;
      if (bus.wbs_ack_o) begin rd = bus.wbs_dat_o; break; end
    end
    check("ack_latency", n, 1);
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] rd;
    wb_access(1, off, data, be, 0, '0, rd);
    model_write(off, data, be, 0, '0);
  endtask

  task automatic wb_read(input string tag, input logic [7:0] off, output logic [31:0] rd);
    wb_access(0, off, 32'h0, 4'hF, 0, '0, rd);
    check(tag, rd, model_read(off));
  endtask

  task automatic core_done(input logic [127:0] dres, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    done_in = 1; dout_core = dres;
    @(posedge clk); #1;
    done_in = 0;
    if (m_busy) begin m_busy = 0; m_done = 1; m_dout = dres; end
  endtask

  task automatic check_outputs(input string tag);
    @(posedge clk); #1;
    check({tag, "_key"}, key, {m_key[0], m_key[1], m_key[2], m_key[3]});
    check({tag, "_din"}, din, {m_din[0], m_din[1], m_din[2], m_din[3]});
    check({tag, "_mode"}, mode, m_mode);
    check({tag, "_irq"}, irq, m_done & m_irq_en);
    check({tag, "_starts"}, start_cnt, m_starts);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    int          acks;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.wbs_ack_o, 0);
    check("rst_dat", bus.wbs_dat_o, 0);
    check("rst_start", start, 0);
    check("rst_irq", irq, 0);
    check("rst_key", key, 0);
    check("rst_din", din, 0);
    check("rst_mode", mode, 0);
    rst_n = 1;
    @(posedge clk); #1;

    wb_read("rst_ctrl", 8'h00, rd);
    wb_read("rst_status", 8'h04, rd);
    wb_read("rst_dout0", 8'h30, rd);
    wb_write(8'h10, 32'hDEADBEEF, 4'hF);
    wb_read("key0_wo", 8'h10, rd);
    check("key0_out", key[127:96], 32'hDEADBEEF);

    wb_write(8'h10, 32'h00010203, 4'hF); wb_write(8'h14, 32'h04050607, 4'hF);
    wb_write(8'h18, 32'h08090a0b, 4'hF); wb_write(8'h1C, 32'h0c0d0e0f, 4'hF);
    wb_write(8'h20, 32'h00112233, 4'hF); wb_write(8'h24, 32'h44556677, 4'hF);
    wb_write(8'h28, 32'h8899aabb, 4'hF); wb_write(8'h2C, 32'hccddeeff, 4'hF);
    wb_write(8'h00, 32'h5, 4'hF);
    check("fips_start_pulse", start_cnt, 1);
    check("fips_mode", mode, 0);
    wb_read("fips_busy", 8'h04, rd);
    check("fips_busy_const", rd, 32'h1);
    core_done(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12);
    check("irq_lag", irq, 0);
    @(posedge clk); #1;
    check("irq_set", irq, 1);
    wb_read("fips_dout0", 8'h30, rd);
    check("fips_dout0_const", rd, 32'h69c4e0d8);
    wb_read("fips_dout3", 8'h3C, rd);
    wb_read("fips_done", 8'h04, rd);
    check("fips_done_const", rd, 32'h2);

    wb_write(8'h00, 32'h5, 4'h1);
    wb_write(8'h20, 32'h12345678, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    wb_read("busy_din0", 8'h20, rd);
    check("busy_din0_const", rd, 32'h00112233);
    wb_read("busy_err", 8'h04, rd);
    check("busy_err_const", rd, 32'h5);
    check("busy_one_start", start_cnt, 2);
    core_done(128'h0123456789abcdef0011223344556677, 5);
    wb_write(8'h04, 32'h4, 4'hF);
    wb_read("err_w1c", 8'h04, rd);
    check("err_w1c_const", rd, 32'h2);

    wb_write(8'h24, 32'hAABBCCDD, 4'b0010);
    wb_read("din1_lane", 8'h24, rd);
    check("din1_lane_const", rd, 32'h4455CC77);

    wb_write(8'h00, 32'h1, 4'h1);
    repeat (4) @(posedge clk);
    #1;
    wb_access(1, 8'h04, 32'h2, 4'hF, 1, 128'hfeedfacecafebabe0123456776543210, rd);
    model_write(8'h04, 32'h2, 4'hF, 1, 128'hfeedfacecafebabe0123456776543210);
    wb_read("set_wins", 8'h04, rd);
    check("set_wins_const", rd, 32'h2);
    core_done(128'h11111111222222223333333344444444, 1);
    wb_read("stray_dout0", 8'h30, rd);
    check("stray_dout0_const", rd, 32'hfeedface);
    wb_read("stray_dout2", 8'h38, rd);

    // Held strobe: ack must alternate and read data must be zero whenever ack is low.
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE | 32'h24;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hold_ack", bus.wbs_ack_o, (i % 2 == 0));
      check("hold_dat", bus.wbs_dat_o, (i % 2 == 0) ? model_read(8'h24) : 32'h0);
    end
    bus_idle();
    @(posedge clk); #1;

    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_1020; bus.wbs_dat_i = 32'h55555555;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check("unsel_no_ack", acks, 0);
    @(posedge clk); #1;
    wb_read("unsel_din0", 8'h20, rd);

    for (int it = 0; it < 200; it++) begin
      logic [7:0]  off;
      logic [31:0] data;
      off = offs[$urandom_range(0, 18)];
      data = $urandom;
      case ($urandom_range(0, 5))
        0: wb_write(off, data, 4'($urandom_range(0, 15)));
        1: wb_read("rnd_read", off, rd);
        2: wb_write(8'h00, {29'h0, data[2:1], 1'b1}, 4'($urandom_range(0, 15)) | 4'h1);
        3: core_done({data, 32'($urandom), 32'($urandom), 32'($urandom)}, $urandom_range(1, 4));
        4: repeat ($urandom_range(1, 5)) @(posedge clk);
        default: wb_write(8'h04, {29'h0, data[2:1], 1'b0}, 4'($urandom_range(0, 15)));
      endcase
      #1;
      check_outputs("rnd");
    end

    wb_write(8'h04, 32'h6, 4'h1);
    if (m_busy) core_done(128'h0, 1);
    wb_write(8'h00, 32'h3, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("midrst_start", start, 0);
    check("midrst_key", key, 0);
    check("midrst_mode", mode, 0);
    model_reset();
    start_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    core_done(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1);
    wb_read("midrst_status", 8'h04, rd);
    check("midrst_status_const", rd, 32'h0);
    wb_read("midrst_dout0", 8'h30, rd);
    check_outputs("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
